// File: rtl/fu_share_arbiter_if.sv
// rtl/fu_share_arbiter_if.sv - request/response bundle between HLSM requesters and the shared functional unit
interface fu_share_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int W   = 16
);
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/fu_share_arbiter.sv
// rtl/fu_share_arbiter.sv - round-robin sharing of one add/sub/mul/gt unit among N requesters
module fu_share_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int W       = 16,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input logic              Clk,
    input logic              Rst,
    fu_share_arbiter_if.slave fu_if
);
    localparam int MAXLAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int CW     = $clog2(MAXLAT) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] tag_q;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic           busy_q;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic [1:0]     op_sel;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   result_d;

    // Scan starts just after the last winner so the previous grantee goes last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % N);
            if (!gnt_found && fu_if.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int j = 0; j < N; j++) begin
            if (IDW'(j) == gnt_idx) begin
                op_sel = fu_if.req_op[2*j +: 2];
                a_sel  = fu_if.req_a[W*j +: W];
                b_sel  = fu_if.req_b[W*j +: W];
            end
        end
    end

    always_comb begin
        result_d = '0;
        case (op_q)
            2'b00:   result_d = a_q + b_q;
            2'b01:   result_d = a_q - b_q;
            2'b10:   result_d = a_q * b_q;
            default: result_d = {{(W-1){1'b0}}, (a_q > b_q)};
        endcase
    end

    assign fu_if.req_ready = (!Rst && state_q == IDLE && gnt_found) ? (N'(1) << gnt_idx) : '0;
    assign fu_if.rsp_valid = rsp_valid_q;
    assign fu_if.rsp_id    = rsp_id_q;
    assign fu_if.rsp_data  = rsp_data_q;
    assign fu_if.busy      = busy_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(N - 1);
            tag_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        op_q     <= op_sel;
                        a_q      <= a_sel;
                        b_q      <= b_sel;
                        tag_q    <= gnt_idx;
                        rr_ptr_q <= gnt_idx;
                        cnt_q    <= (op_sel == 2'b10) ? CW'(MUL_LAT - 1) : CW'(ALU_LAT - 1);
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_data_q  <= result_d;
                        rsp_id_q    <= tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fu_share_arbiter.sv
// tb/tb_fu_share_arbiter.sv - self-checking bench for fu_share_arbiter
module tb_fu_share_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int W       = 16;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fu_share_arbiter_if #(.N(N), .IDW(IDW), .W(W)) fu_if ();

    fu_share_arbiter #(
        .N(N), .IDW(IDW), .W(W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .Clk   (clk),
        .Rst   (rst),
        .fu_if (fu_if)
    );

    typedef struct {
        int id;
        int op;
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 65536;
            1:       return (a - b + 65536) % 65536;
            2:       return int'((longint'(a) * longint'(b)) % 65536);
            default: return (a > b) ? 1 : 0;
        endcase
    endfunction

    function automatic int lat_of(input int op);
        return (op == 2) ? MUL_LAT : ALU_LAT;
    endfunction

    task automatic clear_req();
        fu_if.req_valid = '0;
        fu_if.req_op    = '0;
        fu_if.req_a     = '0;
        fu_if.req_b     = '0;
    endtask

    task automatic set_req(input int id, input int op, input int a, input int b);
        fu_if.req_valid[id]       = 1'b1;
        fu_if.req_op[2*id +: 2]   = op[1:0];
        fu_if.req_a[W*id +: W]    = a[W-1:0];
        fu_if.req_b[W*id +: W]    = b[W-1:0];
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        clear_req();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int got;
        int lat;
        got = 0;
        clear_req();
        set_req(v.id, v.op, v.a, v.b);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fu_if.req_ready != '0) begin
                got = 1;
                break;
            end
        end
        if (got == 0) begin
            chk("vec_grant_timeout", 0, 1);
            return;
        end
        chk("vec_grant_onehot", fu_if.req_ready, 1 << v.id);
        lat = lat_of(v.op);
        @(posedge clk);
        #1 clear_req();
        for (int t = 1; t <= lat + 2; t++) begin
            @(negedge clk);
            if (t <= lat) begin
                chk("vec_exec_rsp_valid", fu_if.rsp_valid, 0);
                chk("vec_exec_busy", fu_if.busy, 1);
                chk("vec_exec_ready", fu_if.req_ready, 0);
            end else if (t == lat + 1) begin
                chk("vec_rsp_valid", fu_if.rsp_valid, 1);
                chk("vec_rsp_busy", fu_if.busy, 1);
                chk("vec_rsp_data", fu_if.rsp_data, v.exp);
                chk("vec_rsp_id", fu_if.rsp_id, v.id);
            end else begin
                chk("vec_post_rsp_valid", fu_if.rsp_valid, 0);
                chk("vec_post_busy", fu_if.busy, 0);
                chk("vec_post_data_hold", fu_if.rsp_data, v.exp);
            end
        end
    endtask

    // Held adds on every requester in mask; grants must follow e[] and be LAT+2 apart.
    task automatic rr_seq(input logic [N-1:0] mask, input int e[8], input int n);
        int last;
        int got;
        last = -1;
        clear_req();
        for (int i = 0; i < N; i++)
            if (mask[i]) set_req(i, 0, i, 1);
        for (int g = 0; g < n; g++) begin
            got = 0;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (fu_if.req_ready != '0) begin
                    got = 1;
                    break;
                end
            end
            if (got == 0) begin
                chk("rr_grant_timeout", 0, 1);
                clear_req();
                return;
            end
            chk("rr_grant", fu_if.req_ready, 1 << e[g]);
            if (last >= 0) chk("rr_spacing", cyc - last, ALU_LAT + 2);
            last = cyc;
            @(negedge clk);
            chk("rr_exec_no_grant", fu_if.req_ready, 0);
            chk("rr_exec_no_rsp", fu_if.rsp_valid, 0);
            @(negedge clk);
            chk("rr_resp_no_grant", fu_if.req_ready, 0);
            chk("rr_rsp_valid", fu_if.rsp_valid, 1);
            chk("rr_rsp_id", fu_if.rsp_id, e[g]);
        end
        @(posedge clk);
        #1 clear_req();
    endtask

    int r_vld[N];
    int r_op[N];
    int r_a[N];
    int r_b[N];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int e_rr[8];
        int e_fair[8];
        int got;
        int m_ptr, next_free, grant_cyc, rsp_cyc, pend_d, pend_id, last_d, last_id;
        int exp_ready, exp_busy, exp_rv, w, any;

        vecs[0] = '{0, 0, 3, 5, 8};
        vecs[1] = '{2, 2, 300, 300, 24464};
        vecs[2] = '{1, 1, 2, 5, 65533};
        vecs[3] = '{3, 3, 7, 7, 0};
        vecs[4] = '{1, 3, 8, 7, 1};
        vecs[5] = '{0, 3, 65535, 1, 1};
        vecs[6] = '{2, 0, 65535, 1, 0};
        vecs[7] = '{3, 2, 65535, 65535, 1};
        e_rr   = '{0, 1, 2, 3, 0, 0, 0, 0};
        e_fair = '{1, 3, 1, 0, 0, 0, 0, 0};

        // Reset state, with every requester asking: grants must stay masked.
        clear_req();
        fu_if.req_valid = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", fu_if.req_ready, 0);
        chk("rst_rsp_valid", fu_if.rsp_valid, 0);
        chk("rst_busy", fu_if.busy, 0);
        chk("rst_rsp_id", fu_if.rsp_id, 0);
        chk("rst_rsp_data", fu_if.rsp_data, 0);

        do_reset();
        foreach (vecs[i]) run_op(vecs[i]);

        do_reset();
        rr_seq(4'b1111, e_rr, 5);
        do_reset();
        rr_seq(4'b1010, e_fair, 3);

        // Reset in the second EXEC cycle of a mul aborts it without a response.
        do_reset();
        clear_req();
        set_req(2, 2, 300, 300);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fu_if.req_ready != '0) begin
                got = 1;
                break;
            end
        end
        chk("abort_grant_seen", got, 1);
        @(posedge clk);
        #1 clear_req();
        @(posedge clk);
        #1 rst = 1'b1;
        set_req(0, 0, 1, 1);
        set_req(2, 0, 1, 1);
        @(negedge clk);
        chk("abort_ready_in_rst", fu_if.req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", fu_if.rsp_valid, 0);
            chk("abort_busy", fu_if.busy, 0);
        end
        @(posedge clk);
        #1 set_req(0, 0, 1, 1);
        set_req(2, 0, 1, 1);
        @(negedge clk);
        chk("abort_first_grant", fu_if.req_ready, 1);
        @(posedge clk);
        #1 clear_req();
        repeat (4) @(posedge clk);

        // Randomized traffic against a timestamp-based reference.
        #1 rst = 1'b1;
        clear_req();
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = N - 1;
        next_free = 0;
        grant_cyc = -100;
        rsp_cyc = -100;
        pend_d = 0;
        pend_id = 0;
        last_d = 0;
        last_id = 0;
        for (int k = 0; k < 1500; k++) begin
            clear_req();
            for (int i = 0; i < N; i++) begin
                r_vld[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1));
                r_op[i]  = int'($urandom_range(0, 3));
                r_a[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
                r_b[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
                if (r_vld[i] != 0) set_req(i, r_op[i], r_a[i], r_b[i]);
            end
            @(negedge clk);
            exp_ready = 0;
            any = 0;
            for (int i = 0; i < N; i++) if (r_vld[i] != 0) any = 1;
            if (k >= next_free && any != 0) begin
                w = -1;
                for (int s = 1; s <= N; s++)
                    if (w < 0 && r_vld[(m_ptr + s) % N] != 0) w = (m_ptr + s) % N;
                exp_ready = 1 << w;
                m_ptr     = w;
                grant_cyc = k;
                rsp_cyc   = k + lat_of(r_op[w]) + 1;
                next_free = k + lat_of(r_op[w]) + 2;
                pend_d    = ref_alu(r_op[w], r_a[w], r_b[w]);
                pend_id   = w;
            end
            exp_rv   = (k == rsp_cyc) ? 1 : 0;
            exp_busy = (k > grant_cyc && k <= rsp_cyc) ? 1 : 0;
            if (exp_rv != 0) begin
                last_d  = pend_d;
                last_id = pend_id;
            end
            chk("rnd_ready", fu_if.req_ready, exp_ready);
            chk("rnd_rsp_valid", fu_if.rsp_valid, exp_rv);
            chk("rnd_busy", fu_if.busy, exp_busy);
            chk("rnd_rsp_data", fu_if.rsp_data, last_d);
            chk("rnd_rsp_id", fu_if.rsp_id, last_id);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/fu_share_arbiter.md
Name: fu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one arithmetic functional unit among N HLSM datapath requesters. The unit does add, sub, mul and unsigned greater-than.
- It accepts one operation at a time, runs it for a fixed per-op latency, and returns a single-cycle tagged response.
- It sits between scheduled state machines and the single physical adder/multiplier the scheduler allocates to them.

Parameters:
- N, 4, number of requesters.
- IDW, 2, width of requester ID; must satisfy 2^IDW >= N.
- W, 16, operand and result width.
- ALU_LAT, 1, EXEC cycles for add/sub/gt; must be >= 1.
- MUL_LAT, 3, EXEC cycles for mul; must be >= 1.

Ports:
- Clk, input, 1, clock.
- Rst, input, 1, synchronous active-high reset.
- req_valid, input, N, per-requester request.
- req_op, input, 2*N, op for requester i at bits [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 gt.
- req_a, input, W*N, operand A for requester i at bits [W*i+W-1:W*i].
- req_b, input, W*N, operand B, same packing as req_a.
- req_ready, output, N, one-hot grant; operands are captured at the clock edge that ends a cycle in which the bit is high.
- rsp_valid, output, 1, single-cycle response strobe.
- rsp_id, output, IDW, index of the requester being answered.
- rsp_data, output, W, result.
- busy, output, 1, high in EXEC and RESP.

Behaviour:
- Reset and reset values:
  - Rst is synchronous, active-high; clock is Clk.
  - On reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, rr_ptr=N-1 (requester 0 has first priority).
  - req_ready is combinational and forced to all-zero while Rst=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req_valid is nonzero, the winner g is the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo N.
  - req_ready[g]=1 for that cycle only.
  - At the edge: capture op/a/b of g, store g as tag, rr_ptr<=g.
  - Load the counter with MUL_LAT-1 for mul, else ALU_LAT-1. Go to EXEC.
  - If req_valid is zero, stay in IDLE with req_ready=0.
- EXEC:
  - req_ready=0.
  - Counter nonzero: decrement.
  - Counter zero: register the result into rsp_data and tag into rsp_id, set rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle, then rsp_valid<=0 and go to IDLE.
  - No grant is issued in RESP.
- Timing, for a grant in cycle c:
  - EXEC occupies c+1 .. c+LAT.
  - rsp_valid is high in c+LAT+1.
  - The earliest next grant is in c+LAT+2.
  - Throughput is one op per LAT+2 cycles.
- Arithmetic, all modulo 2^W, unsigned:
  - add = a+b.
  - sub = a-b.
  - mul = low W bits of the 2W-bit product.
  - gt = {W-1 zeros, (a>b)}.
- rsp_data and rsp_id hold their last value outside rsp_valid.
- Requester rules:
  - A requester holds req_valid and operands stable until its req_ready.
  - Dropping req_valid before a grant is legal: the request is simply not granted.
  - Operand changes after the capture edge have no effect.
- Arbitration and pointer:
  - A requester whose request is still valid after its response competes normally.
  - With other requests pending it is served last, because of the round-robin order.
  - The pointer moves only on grant, never on idle cycles.
- Rst during EXEC or RESP: abort immediately. No rsp_valid is produced (a pending strobe is suppressed), and rr_ptr returns to N-1.
- Illegal parameters (LAT=0, 2^IDW<N) are out of scope and are not checked.

Test Plan:
- Reset, then requester 0 add 3+5, ALU_LAT=1: req_ready=0001 in cycle c, rsp_valid in c+2 with rsp_data=8, rsp_id=0, busy high in c+1..c+2.
- Requester 2 mul 300*300: rsp_data=24464 (90000 mod 65536), rsp_id=2, rsp_valid exactly in c+4, one cycle wide.
- Requester 1 sub 2-5 -> 65533. gt 7,7 -> 0. gt 8,7 -> 1. gt 0xFFFF,1 -> 1 (unsigned).
- All four hold req_valid with adds after reset: grant order 0,1,2,3,0. Grants are spaced 3 cycles apart. Each rsp_id matches its grant.
- Fairness: requesters 1 and 3 held, rr_ptr=3 -> grant 1 then 3 then 1. No grant ever appears during EXEC/RESP.
- Rst pulsed in the second EXEC cycle of a mul from requester 2: no rsp_valid in the following cycles, busy=0 after reset. With requesters 0 and 2 then valid, the first grant goes to 0.
